// File: rtl/ones_comp_checksum.sv
// ones_comp_checksum: streaming ones'-complement sum with end-around carry fold.
// Define CHECKSUM_INVERT_EN to emit the complemented (Internet-checksum style) result.
module ones_comp_checksum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             last,
    output logic [WIDTH-1:0] sum_out,
    output logic             sum_valid,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic             cnt_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] acc, opnd, result;
    logic c, xfer;
    logic [WIDTH:0] add_sum;
    assign xfer = in_valid && in_ready;
    // The same adder serves transfers (acc + word + c) and folds (acc + c).
    assign opnd = (state == ACCUM) ? data_in : '0;
    assign add_sum = {1'b0, acc} + {1'b0, opnd} + {{WIDTH{1'b0}}, c};
`ifdef CHECKSUM_INVERT_EN
    assign result = ~acc;
`else
    assign result = acc;
`endif
    always_comb begin
        state_nxt = state;
        in_ready = (state == ACCUM);
        busy = (state == ACCUM) || (state == FOLD);
        case (state)
            IDLE:    state_nxt = start ? ACCUM : IDLE;
            ACCUM:   state_nxt = (xfer && last) ? FOLD : ACCUM;
            FOLD:    state_nxt = add_sum[WIDTH] ? FOLD : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc <= '0;
            c <= 1'b0;
            sum_out <= '0;
            sum_valid <= 1'b0;
            word_cnt <= '0;
            cnt_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            sum_valid <= (state == DONE);
            if (state == IDLE && start) begin
                acc <= '0;
                c <= 1'b0;
                word_cnt <= '0;
                cnt_ovf <= 1'b0;
            end
            if (xfer || state == FOLD)
                {c, acc} <= add_sum;
            if (xfer) begin
                if (&word_cnt)
                    cnt_ovf <= 1'b1;
                else
                    word_cnt <= word_cnt + 1'b1;
            end
            if (state == DONE)
                sum_out <= result;
        end
    end
endmodule

// File: tb/tb_ones_comp_checksum.sv
// tb_ones_comp_checksum: message-level model checked every cycle on two counter widths,
// plus literal per-scenario expectations.
module tb_ones_comp_checksum;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, last = 1'b0;
    logic [15:0] data_in = '0;
    logic        r8, v8, b8, o8, r2, v2, b2, o2;
    logic [15:0] s8, s2;
    logic [7:0]  c8;
    logic [1:0]  c2;
    int tests = 0, fails = 0;
    bit m_open = 0, m_valid = 0;
    int m_tail = 0, m_n = 0;
    longint m_total = 0;
    logic [15:0] m_sum = '0;

    always #5 clk = ~clk;

    ones_comp_checksum #(.WIDTH(16), .CNT_W(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(r8),
        .data_in(data_in), .last(last), .sum_out(s8), .sum_valid(v8), .busy(b8),
        .word_cnt(c8), .cnt_ovf(o8));
    ones_comp_checksum #(.WIDTH(16), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(r2),
        .data_in(data_in), .last(last), .sum_out(s2), .sum_valid(v2), .busy(b2),
        .word_cnt(c2), .cnt_ovf(o2));

    function automatic logic [15:0] lit(input logic [15:0] raw);
`ifdef CHECKSUM_INVERT_EN
        return ~raw;
`else
        return raw;
`endif
    endfunction

    // Ones'-complement sum of a message = plain total folded until it fits 16 bits.
    function automatic logic [15:0] fold(input longint t);
        longint v = t;
        while ((v >> 16) != 0) v = (v & 64'hFFFF) + (v >> 16);
        return lit(v[15:0]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("in_ready8", {31'd0, r8}, {31'd0, m_open});
        chk("in_ready2", {31'd0, r2}, {31'd0, m_open});
        chk("busy8", {31'd0, b8}, {31'd0, m_open || m_tail == 2});
        chk("busy2", {31'd0, b2}, {31'd0, m_open || m_tail == 2});
        chk("sum_valid8", {31'd0, v8}, {31'd0, m_valid});
        chk("sum_valid2", {31'd0, v2}, {31'd0, m_valid});
        chk("sum_out8", {16'd0, s8}, {16'd0, m_sum});
        chk("sum_out2", {16'd0, s2}, {16'd0, m_sum});
        chk("word_cnt8", {24'd0, c8}, (m_n > 255) ? 32'd255 : m_n);
        chk("word_cnt2", {30'd0, c2}, (m_n > 3) ? 32'd3 : m_n);
        chk("cnt_ovf8", {31'd0, o8}, {31'd0, m_n > 255});
        chk("cnt_ovf2", {31'd0, o2}, {31'd0, m_n > 3});
        // Advance the model to what must hold after the coming rising edge.
        if (reset) begin
            m_open = 0; m_tail = 0; m_n = 0; m_total = 0; m_sum = '0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (m_tail == 1) begin
                m_sum = fold(m_total); m_valid = 1; m_tail = 0;
            end else if (m_tail == 2) m_tail = 1;
            else if (m_open) begin
                if (in_valid) begin
                    m_n++; m_total += data_in;
                    if (last) begin m_open = 0; m_tail = 2; end
                end
            end else if (start) begin
                m_open = 1; m_n = 0; m_total = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic go();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1; data_in = d; last = l;
        cyc();
        in_valid = 1'b0; last = 1'b0;
    endtask

    // Waits for sum_valid after the last transfer; optionally pulses start in the DONE cycle.
    task automatic wait_done(input string nm, input logic [15:0] raw, input int cnt, input bit poke);
        int lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            start = 1'b0;
            if (v8) begin lat = i; break; end
            if (poke && i == 1) start = 1'b1;
        end
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_sum"}, {16'd0, s8}, {16'd0, lit(raw)});
        chk({nm, "_cnt"}, {24'd0, c8}, cnt);
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_sum_out", {16'd0, s8}, 0);
        chk("rst_busy", {31'd0, b8}, 0);
        chk("rst_in_ready", {31'd0, r8}, 0);
        chk("rst_word_cnt", {24'd0, c8}, 0);
        reset = 1'b0;
        cyc();
        go(); send(16'h1234, 0); send(16'h4321, 1);
        wait_done("basic", 16'h5555, 2, 0);
        go(); send(16'hFFFF, 0); send(16'h0001, 1);
        wait_done("eac", 16'h0001, 2, 0);
        go(); send(16'hFFFF, 0); send(16'hFFFF, 0); send(16'hFFFF, 1);
        wait_done("negzero", 16'hFFFF, 3, 1);
        cyc();
        chk("done_start_ignored", {31'd0, r8}, 0);
        go(); cyc(); send(16'h5A5A, 0); in_valid = 1'b0;
        start = 1'b1; cyc(); start = 1'b0; cyc();
        chk("hold_cnt", {24'd0, c8}, 1);
        send(16'hA5A5, 0); cyc(); send(16'h0000, 1);
        wait_done("gaps", 16'hFFFF, 3, 0);
        in_valid = 1'b1; data_in = 16'hFFFF; last = 1'b1; cyc(); cyc();
        in_valid = 1'b0; last = 1'b0;
        chk("idle_in_ignored", {24'd0, c8}, 3);
        go(); send(16'h0000, 1);
        wait_done("zero", 16'h0000, 1, 0);
        go(); send(16'h1111, 0); send(16'h2222, 0);
        in_valid = 1'b1; data_in = 16'h3333; reset = 1'b1; cyc();
        reset = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, b8}, 0);
        chk("abort_in_ready", {31'd0, r8}, 0);
        chk("abort_sum", {16'd0, s8}, 0);
        chk("abort_cnt", {24'd0, c8}, 0);
        cyc(); cyc(); cyc();
        go(); send(16'h0F0F, 0); send(16'hF0F0, 1);
        wait_done("fresh", 16'hFFFF, 2, 0);
        go();
        for (int i = 0; i < 5; i++) send(16'h0001, i == 4);
        wait_done("sat", 16'h0005, 5, 0);
        chk("sat_cnt2", {30'd0, c2}, 3);
        chk("sat_ovf2", {31'd0, o2}, 1);
        chk("sat_ovf8", {31'd0, o8}, 0);
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ones_comp_checksum.md
ONES_COMP_CHECKSUM -- requirements
Module: ones_comp_checksum

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 16: data and sum width in bits, minimum 4.
REQ-003 Parameter CNT_W, default 8: word-counter width in bits.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  begin a new checksum; sampled only in IDLE.
REQ-007 Port in_valid  input  1  data_in and last are valid this cycle.
REQ-008 Port in_ready  output  1  block accepts a word this cycle.
REQ-009 Port data_in  input  WIDTH  operand word.
REQ-010 Port last  input  1  the accepted word is the final word of the message.
REQ-011 Port sum_out  output  WIDTH  final result; held until the next start.
REQ-012 Port sum_valid  output  1  one-cycle pulse when sum_out is updated.
REQ-013 Port busy  output  1  high in ACCUM and FOLD.
REQ-014 Port word_cnt  output  CNT_W  words accepted in the current or last message, saturating.
REQ-015 Port cnt_ovf  output  1  sticky; word_cnt saturated during the current or last message.

Function
REQ-016 States SHALL be IDLE, ACCUM, FOLD and DONE.
REQ-017 IDLE with start=1 SHALL clear acc, carry register c, word_cnt and cnt_ovf, then enter ACCUM on the next cycle.
REQ-018 in_ready SHALL be 1 only in ACCUM; a transfer occurs when in_valid && in_ready.
REQ-019 On a transfer, {c, acc} SHALL be set to acc + data_in + c, a (WIDTH+1)-bit sum with the carry registered for the next add.
REQ-020 On a transfer, word_cnt SHALL increment by 1 and hold at all-ones; an increment attempted at all-ones SHALL set cnt_ovf.
REQ-021 A transfer with last=1 SHALL move the state to FOLD.
REQ-022 FOLD SHALL set {c, acc} to acc + c each cycle and remain in FOLD while the result carry is 1; it SHALL exit to DONE when c=0 after the add. The maximum time in FOLD is 2 cycles.
REQ-023 DONE SHALL last exactly one cycle: it loads sum_out, pulses sum_valid and returns to IDLE.
REQ-024 Latency from the last transfer to sum_valid SHALL be 2 cycles without a second fold and 3 cycles with one.
REQ-025 in_valid outside ACCUM SHALL be ignored, with no state change.
REQ-026 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-027 in_valid=0 in ACCUM SHALL hold all state; there is no timeout.
REQ-028 Negative zero (all-ones) SHALL be a legal raw sum and SHALL NOT be normalised.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and SHALL clear acc, c, sum_out, sum_valid, word_cnt and cnt_ovf to 0.
REQ-030 in_ready and busy SHALL be 0 from the first cycle after a reset edge.
REQ-031 reset SHALL take priority over start, transfers and FOLD in the same cycle; a message in progress is discarded and no sum_valid is emitted.

Configuration
REQ-032 Macro CHECKSUM_INVERT_EN defined: DONE SHALL load sum_out with the bitwise complement of acc (Internet-checksum style).
REQ-033 Macro CHECKSUM_INVERT_EN undefined: DONE SHALL load sum_out with acc unchanged (raw ones'-complement sum).

Verification
All scenarios use WIDTH=16.
REQ-034 Scenario: start; words 0x1234, 0x4321(last) -> raw 0x5555, inverted 0xAAAA; sum_valid 2 cycles after the last transfer; word_cnt=2.
REQ-035 Scenario: words 0xFFFF, 0x0001(last) -> end-around carry gives raw 0x0001, inverted 0xFFFE.
REQ-036 Scenario: words 0xFFFF, 0xFFFF, 0xFFFF(last) -> raw 0xFFFF, inverted 0x0000; covers acc=0xFFFE with c=1 before the fold.
REQ-037 Scenario: single word 0x0000(last), with in_valid toggled 0/1 in ACCUM and start pulsed while busy -> raw 0x0000, inverted 0xFFFF; ignored inputs leave word_cnt=1.
REQ-038 Scenario: reset asserted after 2 of 4 words -> IDLE, all outputs 0, no sum_valid; a fresh message 0x0F0F, 0xF0F0(last) then yields raw 0xFFFF.
REQ-039 Scenario: CNT_W=2; 5 words of 0x0001 -> word_cnt=3, cnt_ovf=1, raw sum 0x0005.
